// File: rtl/mct_cascade_engine_if.sv
// Handshake and configuration bundle for the MCT cascade engine.
// The master side (the register file / test source) loads gates and launches
// jobs; the slave side is the engine itself.
interface mct_cascade_engine_if #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             cfg_we;
   logic [AW-1:0]    cfg_addr;
   logic [WIDTH-1:0] cfg_ctrl;
   logic [WIDTH-1:0] cfg_tgt;
   logic             cfg_err;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AW:0]      in_len;
   logic             in_dir;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;

   modport master (
      output cfg_we, cfg_addr, cfg_ctrl, cfg_tgt,
      output in_valid, in_data, in_len, in_dir, out_ready,
      input  cfg_err, in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_ctrl, cfg_tgt,
      input  in_valid, in_data, in_len, in_dir, out_ready,
      output cfg_err, in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/mct_cascade_engine.sv
// Sequential multiple-control Toffoli cascade processor.
// Holds a program of DEPTH reversible gates and applies the first len of them
// to a word, one gate per cycle, forward (slot 0 up) or reverse (slot len-1
// down). Because every MCT gate is self-inverse, a reverse run undoes a
// forward run of the same length.
module mct_cascade_engine #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   mct_cascade_engine_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           fsm_q;
   logic [WIDTH-1:0] ctrl_q [DEPTH];
   logic [WIDTH-1:0] tgt_q  [DEPTH];
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_d;
   logic [WIDTH-1:0] outData_q;
   logic [AW-1:0]    ptr_q;
   logic [AW:0]      cnt_q;
   logic             dir_q;
   logic             inReady_q;
   logic             outValid_q;
   logic             busy_q;
   logic             cfgErr_q;

   logic             cfgLegal;
   logic [AW:0]      lenClamp;
   logic [AW-1:0]    ptrStart;
   logic [WIDTH-1:0] gateCtrl;
   logic [WIDTH-1:0] gateTgt;

   // Decode write legality, clamp the job length, and evaluate the current gate
   always_comb begin
      cfgLegal = ((bus.cfg_ctrl & bus.cfg_tgt) == '0)
                 && ({1'b0, bus.cfg_addr} < DEPTH_W)
                 && (fsm_q == IDLE);
      lenClamp = (bus.in_len > DEPTH_W) ? DEPTH_W : bus.in_len;
      ptrStart = AW'(lenClamp - CNT_ONE);
      gateCtrl = ctrl_q[ptr_q];
      gateTgt  = tgt_q[ptr_q];
      word_d   = ((word_q & gateCtrl) == gateCtrl) ? (word_q ^ gateTgt) : word_q;
   end

   // Gate program store: accepts only reversible gates while idle, flags rejects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_q[i] <= '0;
            tgt_q[i]  <= '0;
         end
         cfgErr_q <= 1'b0;
      end else begin
         cfgErr_q <= bus.cfg_we && !cfgLegal;
         if (bus.cfg_we && cfgLegal) begin
            ctrl_q[bus.cfg_addr] <= bus.cfg_ctrl;
            tgt_q[bus.cfg_addr]  <= bus.cfg_tgt;
         end
      end
   end

   // Job sequencer: launch, step one gate per cycle, hold the result until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q      <= IDLE;
         word_q     <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (bus.in_valid && inReady_q) begin
                  word_q    <= bus.in_data;
                  dir_q     <= bus.in_dir;
                  cnt_q     <= lenClamp;
                  ptr_q     <= bus.in_dir ? ptrStart : '0;
                  inReady_q <= 1'b0;
                  busy_q    <= 1'b1;
                  if (lenClamp != '0) begin
                     fsm_q <= RUN;
                  end else begin
                     fsm_q      <= DONE;
                     outValid_q <= 1'b1;
                     outData_q  <= bus.in_data;
                  end
               end
            end
            RUN: begin
               word_q <= word_d;
               cnt_q  <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  fsm_q      <= DONE;
                  outValid_q <= 1'b1;
                  outData_q  <= word_d;
               end else begin
                  ptr_q <= dir_q ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  fsm_q      <= IDLE;
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            default: begin
               fsm_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.cfg_err   = cfgErr_q;
   assign bus.in_ready  = inReady_q;
   assign bus.out_valid = outValid_q;
   assign bus.out_data  = outData_q;
   assign bus.busy      = busy_q;

endmodule
